paddle_update_sched: RTL

//  Schedules per-frame position updates for both Pong paddles through one shared

---
 rtl/paddle_update_sched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/paddle_update_sched.sv
// paddle_update_sched: frame-synchronous position update for both Pong paddles.
// One step/clamp unit is time-shared between the two players (UPD0 then UPD1);
// results land in shadow registers and both coordinates commit together in COMMIT,
// so the renderer never observes a half-updated pair.
//
// Handshake: frame_tick is a one-cycle request accepted only in IDLE with freeze=0;
// busy is high from the cycle after acceptance until the commit cycle inclusive,
// upd_done pulses for exactly that commit cycle, and ticks seen while busy are dropped.
module paddle_update_sched #(
    parameter int COORD_W  = 9,
    parameter int MAX_Y    = 480,
    parameter int PADDLE_H = 64,
    parameter int STEP     = 4,
    parameter int INIT_Y   = 208
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               freeze,
    input  logic               up0,
    input  logic               down0,
    input  logic               up1,
    input  logic               down1,
    output logic [COORD_W-1:0] coord0,
    output logic [COORD_W-1:0] coord1,
    output logic               busy,
    output logic               upd_done
);

    localparam logic [COORD_W-1:0] STEP_N  = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] LIMIT_N = COORD_W'(MAX_Y - PADDLE_H);
    localparam logic [COORD_W:0]   STEP_W  = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0]   LIMIT_W = (COORD_W+1)'(MAX_Y - PADDLE_H);
    localparam logic [COORD_W-1:0] INIT_N  = COORD_W'(INIT_Y);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPD0   = 2'd1,
        UPD1   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // state is left as a plain named signal so checkers can bind to it
    state_t state;
    state_t state_next;

    logic               req_up0, req_down0, req_up1, req_down1;
    logic [COORD_W-1:0] shadow0, shadow1;

    // shared unit operands and result
    logic [COORD_W-1:0] unit_y;
    logic               unit_up, unit_down;
    logic [COORD_W-1:0] unit_diff;
    logic [COORD_W:0]   unit_sum;
    logic [COORD_W-1:0] unit_result;

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode plus busy/upd_done, both pure functions of the current state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        upd_done   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick && !freeze) state_next = UPD0;
            end
            UPD0: begin
                busy       = 1'b1;
                state_next = UPD1;
            end
            UPD1: begin
                busy       = 1'b1;
                state_next = COMMIT;
            end
            COMMIT: begin
                busy       = 1'b1;
                upd_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shared step/clamp unit: player 1 operands in UPD1, player 0 otherwise.
    always_comb begin
        unit_y      = (state == UPD1) ? shadow1   : shadow0;
        unit_up     = (state == UPD1) ? req_up1   : req_up0;
        unit_down   = (state == UPD1) ? req_down1 : req_down0;
        unit_diff   = unit_y - STEP_N;
        unit_sum    = {1'b0, unit_y} + STEP_W;
        unit_result = unit_y;
        if (unit_up && !unit_down) begin
            unit_result = (unit_y < STEP_N) ? '0 : unit_diff;
        end else if (unit_down && !unit_up) begin
            unit_result = (unit_sum > LIMIT_W) ? LIMIT_N : unit_sum[COORD_W-1:0];
        end
    end

    // Datapath: latch requests at the tick, compute each shadow in turn, commit both at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            coord0    <= INIT_N;
            coord1    <= INIT_N;
            shadow0   <= INIT_N;
            shadow1   <= INIT_N;
            req_up0   <= 1'b0;
            req_down0 <= 1'b0;
            req_up1   <= 1'b0;
            req_down1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_tick && !freeze) begin
                        req_up0   <= up0;
                        req_down0 <= down0;
                        req_up1   <= up1;
                        req_down1 <= down1;
                        shadow0   <= coord0;
                        shadow1   <= coord1;
                    end
                end
                UPD0:    shadow0 <= unit_result;
                UPD1:    shadow1 <= unit_result;
                COMMIT: begin
                    coord0 <= shadow0;
                    coord1 <= shadow1;
                end
                default: ;
            endcase
        end
    end

endmodule
